// File: rtl/cpu_mem_scheduler.sv
// Cycle scheduler for the 6502 core and shared system RAM: 2 MHz video/CPU
// interleave from a 16 MHz clock, with 1 MHz stretching for slow peripherals.
module cpu_mem_scheduler #(
  parameter logic [15:0] RAM_TOP = 16'h8000,
  parameter bit          SLOW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  output logic        cpu_clk_en,
  output logic        phi2,
  output logic        ram_owner,
  output logic        vid_strobe,
  output logic        ram_we,
  output logic        slow_cycle,
  output logic        mhz1_en
);

  typedef enum logic {
    IDLE_CYC,
    STRETCH
  } state_t;

  state_t     state;
  logic [2:0] p;
  logic       m;
  logic [1:0] extra;
  logic       first_slot;
  logic       wr_pend;
  logic       slow_hit;
  logic       final_slot;

  // 1 MHz peripheral windows: FC00-FDFF, FE00-FE1F, FE40-FE7F.
  always_comb begin
    slow_hit = SLOW_EN &&
               ((cpu_addr[15:9] == 7'h7E)  ||
                (cpu_addr[15:5] == 11'h7F0) ||
                (cpu_addr[15:6] == 10'h3F9));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      p          <= 3'd0;
      m          <= 1'b0;
      state      <= IDLE_CYC;
      extra      <= 2'd0;
      first_slot <= 1'b0;
      wr_pend    <= 1'b0;
    end else begin
      p <= p + 3'd1;
      if (p == 3'd7) begin
        m       <= ~m;
        wr_pend <= 1'b0;
      end

      // Address and direction are only looked at once per CPU cycle, at p == 0.
      unique case (state)
        IDLE_CYC: begin
          if (p == 3'd0) begin
            wr_pend <= ~cpu_rnw && (cpu_addr < RAM_TOP);
            if (slow_hit) begin
              state      <= STRETCH;
              extra      <= m ? 2'd2 : 2'd1;
              first_slot <= 1'b1;
            end
          end
        end
        STRETCH: begin
          if (p == 3'd7) begin
            first_slot <= 1'b0;
            if (extra == 2'd0) state <= IDLE_CYC;
            else               extra <= extra - 2'd1;
          end
        end
        default: state <= IDLE_CYC;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they never see input glitches.
  always_comb begin
    final_slot = (state == IDLE_CYC) || (extra == 2'd0);
    ram_owner  = p[2];
    vid_strobe = (p == 3'd3);
    cpu_clk_en = (p == 3'd7) && final_slot;
    mhz1_en    = (p == 3'd7) && m;
    slow_cycle = (state == STRETCH);
    phi2       = p[2] || ((state == STRETCH) && !first_slot);
    ram_we     = (p == 3'd6) && wr_pend;
  end

endmodule

// File: doc/cpu_mem_scheduler.md
# cpu_mem_scheduler

Cycle scheduler for the 6502 core and shared system RAM. From the single system clock it generates the CPU cycle enable and PHI_2 window and interleaves RAM ownership between video and CPU at 2 MHz each. It stretches CPU cycles that address 1 MHz peripherals so they finish on a 1 MHz boundary. It sits between the CPU core, the RAM/address decode and the video fetch logic.

## Interface
- RAM_TOP, 16'h8000: first address above RAM; CPU addresses below it are RAM.
- SLOW_EN, 1: 1 enables 1 MHz stretching; 0 never stretches.

Ports:
- clk  in  1  system clock, 16 MHz; rising-edge only.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address, stable from one cpu_clk_en to the next.
- cpu_rnw  in  1  CPU read (1) / write (0).
- cpu_clk_en  out  1  one-clk pulse; the CPU core advances one cycle on it.
- phi2  out  1  CPU data-phase window.
- ram_owner  out  1  0 = video owns RAM, 1 = CPU owns RAM.
- vid_strobe  out  1  one-clk pulse; video latches the RAM data.
- ram_we  out  1  one-clk RAM write strobe for the CPU.
- slow_cycle  out  1  high for the whole of a stretched CPU cycle.
- mhz1_en  out  1  one-clk pulse at the end of each 1 MHz period.

## Operation
- 3-bit phase counter p, 0..7, wraps 7 -> 0. One wrap is one 2 MHz slot.
- 1-bit m toggles when p == 7; it marks the 1 MHz half (0 = low, 1 = high).
- RAM ownership:
  - p 0..3: ram_owner = 0, video slot. vid_strobe pulses at p == 3.
  - p 4..7: ram_owner = 1, CPU slot.
  - Video slots are never skipped, including during stretch.
- Slow decode: cpu_addr in FC00–FDFF, FE00–FE1F or FE40–FE7F, and SLOW_EN == 1.
- State machine, states IDLE_CYC and STRETCH, with a 2-bit counter extra:
  - In IDLE_CYC at p == 0, the slow decode is evaluated.
  - If slow and m == 0: extra = 1, go to STRETCH.
  - If slow and m == 1: extra = 2, go to STRETCH.
  - Otherwise the cycle is normal.
  - In STRETCH, at each p == 7: if extra == 0, assert cpu_clk_en and go to IDLE_CYC; else decrement extra.
  - A stretched access therefore always ends on a slot with m == 1.
- cpu_clk_en pulses at p == 7 of a normal cycle, or of the final stretched slot.
- slow_cycle is high from p == 1 of the first slot through p == 7 of the final slot.
- phi2:
  - Normal cycle: high for p 4..7.
  - Stretched cycle: high from p == 4 of the first slot through p == 7 of the final slot, continuously, video slots included.
- ram_we pulses at p == 6 when cpu_rnw == 0 and cpu_addr < RAM_TOP. There is exactly one pulse per CPU cycle, in the first slot only.
- mhz1_en pulses at p == 7 when m == 1.

## Timing
- Reset values:
  - p = 0, m = 0, state IDLE_CYC, extra = 0.
  - cpu_clk_en, phi2, ram_owner, vid_strobe, ram_we, slow_cycle and mhz1_en are all 0.
- First clock after reset deasserts has p == 0.
- All outputs are registered, or decoded purely from registered p, m and state; there are no combinational paths from the inputs.
- Latency from one cpu_clk_en to the next:
  - Normal: 8 clk.
  - Slow with m == 0: 16 clk.
  - Slow with m == 1: 24 clk.
- cpu_addr changing mid-cycle has no effect; it is sampled only at p == 0 in IDLE_CYC.
- Reset asserted mid-stretch aborts the stretch. The next cycle after reset is a fresh slot with p == 0 and state IDLE_CYC; no cpu_clk_en or ram_we is emitted for the aborted access.
- Simultaneous events at p == 7 with m == 1: mhz1_en and cpu_clk_en both pulse in the same clk, and m toggles to 0.
- A slow write to a non-RAM address never asserts ram_we.

## Test plan
- Reset then free-run with cpu_addr = 0000 and read:
  - cpu_clk_en every 8 clk; vid_strobe every 8 clk, 4 clk before cpu_clk_en.
  - mhz1_en every 16 clk; ram_we never asserted.
- Write to 1234: ram_we exactly once per cycle at p == 6 with ram_owner == 1; write to C000 gives no ram_we.
- Slow read FE40 presented when m == 0: slow_cycle high; next cpu_clk_en 16 clk after the previous one, coinciding with mhz1_en.
- Slow read FC00 presented when m == 1: next cpu_clk_en after 24 clk; phi2 high continuously for 20 clk; 3 vid_strobe pulses occur meanwhile.
- SLOW_EN = 0 with address FE00: 8-clk cycles; slow_cycle stays 0.
- Reset asserted during the second slot of a 24-clk stretch: all outputs 0 next clk; after release, a normal cycle gives cpu_clk_en 8 clk later.
